// File: rtl/lab2_input_conditioner_if.sv
// lab2_input_conditioner_if: bundles the raw board inputs and the conditioned outputs
//   btn_raw/sw_raw       : raw pushbuttons and slide switches (master drives)
//   btn_level/btn_pulse  : debounced button level and press strobe (slave drives)
//   d_sync               : synchronised switch value (slave drives)
interface lab2_input_conditioner_if #(
  parameter int NUM_BTN = 3,
  parameter int DATA_W  = 8
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_pulse;
  logic [DATA_W-1:0]  sw_raw;
  logic [DATA_W-1:0]  d_sync;
  modport master (output btn_raw, sw_raw, input btn_level, btn_pulse, d_sync);
  modport slave  (input btn_raw, sw_raw, output btn_level, btn_pulse, d_sync);
endinterface

// File: rtl/lab2_input_conditioner.sv
// lab2_input_conditioner: synchronises, debounces and edge-detects pushbuttons; synchronises switches
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   io  : lab2_input_conditioner_if.slave (btn_raw, sw_raw in; btn_level, btn_pulse, d_sync out)
//   Optional BTN_AUTOREPEAT_EN: held buttons re-pulse every REPEAT_CYCLES cycles.
module lab2_input_conditioner #(
  parameter int NUM_BTN         = 3,
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 50000000
) (
  input logic clk,
  input logic rst,
  lab2_input_conditioner_if.slave io
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  logic [NUM_BTN-1:0] b1_q, s_q, lvl_q, lvl_d, pls_q, pls_d, chg, acc;
  logic [DATA_W-1:0]  w1_q, d_q;
  logic [CW-1:0]      cnt_q [NUM_BTN];
  logic [CW-1:0]      cnt_d [NUM_BTN];
`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  logic [RW-1:0]      rep_q [NUM_BTN];
  logic [RW-1:0]      rep_d [NUM_BTN];
  logic [NUM_BTN-1:0] hit;
`endif
  always_comb begin
    chg = s_q ^ lvl_q;
    acc = '0;
`ifdef BTN_AUTOREPEAT_EN
    hit = '0;
`endif
    for (int i = 0; i < NUM_BTN; i++) begin
      // cnt counts edges already seen in the changed state; the D-th such edge accepts
      acc[i] = chg[i] && (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1));
      cnt_d[i] = (chg[i] && !acc[i]) ? cnt_q[i] + CW'(1) : '0;
`ifdef BTN_AUTOREPEAT_EN
      // repeat timer runs only while the level is settled high; release or a fresh press clears it
      hit[i] = lvl_q[i] && !acc[i] && (rep_q[i] == RW'(REPEAT_CYCLES - 1));
      rep_d[i] = (lvl_q[i] && !acc[i] && !hit[i]) ? rep_q[i] + RW'(1) : '0;
`endif
    end
    lvl_d = lvl_q ^ acc;
`ifdef BTN_AUTOREPEAT_EN
    pls_d = (acc & ~lvl_q) | hit;
`else
    pls_d = acc & ~lvl_q;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b1_q  <= '0;
      s_q   <= '0;
      w1_q  <= '0;
      d_q   <= '0;
      lvl_q <= '0;
      pls_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      b1_q  <= io.btn_raw;
      s_q   <= b1_q;
      w1_q  <= io.sw_raw;
      d_q   <= w1_q;
      lvl_q <= lvl_d;
      pls_q <= pls_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rep_q <= '{default: '0};
    else      rep_q <= rep_d;
  end
`endif
  assign io.btn_level = lvl_q;
  assign io.btn_pulse = pls_q;
  assign io.d_sync    = d_q;
endmodule

// File: tb/tb_lab2_input_conditioner.sv
// tb_lab2_input_conditioner: directed stimulus with a sample-history model and per-cycle compare
module tb_lab2_input_conditioner;
  localparam int NB = 3;
  localparam int DW = 8;
  localparam int D  = 4;
  localparam int R  = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  lab2_input_conditioner_if #(.NUM_BTN(NB), .DATA_W(DW)) io ();
  lab2_input_conditioner #(
    .NUM_BTN(NB), .DATA_W(DW), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .io (io)
  );
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: sync = pure 2-edge delay; a button level flips once its last D synchronised
  // samples all disagree with the current level; pulses on accepted presses (and repeats).
  logic [NB-1:0] m_p1, m_p2, m_lvl, m_pls;
  logic [DW-1:0] m_w1, m_d;
  logic [D-1:0]  hist [NB];
  int            held [NB];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p1 = '0; m_p2 = '0; m_lvl = '0; m_pls = '0; m_w1 = '0; m_d = '0;
      for (int b = 0; b < NB; b++) begin
        hist[b] = '0;
        held[b] = 0;
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        logic acc_b, rise_b;
        hist[b] = {hist[b][D-2:0], m_p2[b]};
        acc_b = m_lvl[b] ? (hist[b] == '0) : (hist[b] == '1);
        rise_b = acc_b && !m_lvl[b];
        if (acc_b) m_lvl[b] = ~m_lvl[b];
        held[b] = (rise_b || !m_lvl[b]) ? 0 : held[b] + 1;
`ifdef BTN_AUTOREPEAT_EN
        m_pls[b] = rise_b || (m_lvl[b] && held[b] > 0 && held[b] % R == 0);
`else
        m_pls[b] = rise_b;
`endif
      end
      m_p2 = m_p1;
      m_p1 = io.btn_raw;
      m_d  = m_w1;
      m_w1 = io.sw_raw;
    end
  end
  always @(negedge clk) begin
    chk("model_level", 32'(io.btn_level), 32'(m_lvl));
    chk("model_pulse", 32'(io.btn_pulse), 32'(m_pls));
    chk("model_d_sync", 32'(io.d_sync), 32'(m_d));
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    io.btn_raw = '1;
    io.sw_raw  = '1;
    step(1);
    chk("rst_level", 32'(io.btn_level), 0);
    chk("rst_pulse", 32'(io.btn_pulse), 0);
    chk("rst_d_sync", 32'(io.d_sync), 0);
    step(1);
    rst_n = 1'b1;
    io.btn_raw = '0;
    io.sw_raw  = '0;
    step(3);
    io.sw_raw = 8'h15;
    step(1);
    chk("sw_one_edge", 32'(io.d_sync), 0);
    step(1);
    chk("sw_15", 32'(io.d_sync), 32'h15);
    io.sw_raw = 8'hA3;
    step(2);
    chk("sw_A3", 32'(io.d_sync), 32'hA3);
    io.btn_raw[1] = 1'b1;
    step(5);
    chk("b1_before_accept", 32'(io.btn_pulse), 0);
    step(1);
    chk("b1_pulse", 32'(io.btn_pulse), 32'b010);
    chk("b1_level", 32'(io.btn_level), 32'b010);
    step(1);
    chk("b1_pulse_drop", 32'(io.btn_pulse), 0);
    chk("b1_level_hold", 32'(io.btn_level), 32'b010);
    io.btn_raw[0] = 1'b1;
    step(2);
    io.btn_raw[0] = 1'b0;
    step(1);
    io.btn_raw[0] = 1'b1;
    step(5);
    chk("b0_glitch_no_pulse", 32'(io.btn_pulse[0]), 0);
    step(1);
    chk("b0_pulse", 32'(io.btn_pulse[0]), 1);
    step(1);
    chk("b0_single_pulse", 32'(io.btn_pulse[0]), 0);
    io.btn_raw[0] = 1'b0;
    step(6);
    chk("b0_released", 32'(io.btn_level[0]), 0);
    io.btn_raw[0] = 1'b1;
    io.btn_raw[2] = 1'b1;
    step(6);
    chk("simul_pulse", 32'({io.btn_pulse[2], io.btn_pulse[0]}), 32'b11);
    io.btn_raw[0] = 1'b0;
    io.btn_raw[2] = 1'b0;
    step(6);
    chk("simul_release", 32'({io.btn_level[2], io.btn_level[0]}), 0);
    #3 rst_n = 1'b0;
    step(1);
    chk("midrst_level", 32'(io.btn_level), 0);
    chk("midrst_pulse", 32'(io.btn_pulse), 0);
    step(1);
    rst_n = 1'b1;
    step(5);
    chk("postrst_early", 32'(io.btn_pulse[1]), 0);
    step(1);
    chk("postrst_pulse", 32'(io.btn_pulse[1]), 1);
    chk("postrst_level", 32'(io.btn_level), 32'b010);
    step(8);
`ifdef BTN_AUTOREPEAT_EN
    chk("repeat_pulse", 32'(io.btn_pulse[1]), 1);
`else
    chk("no_repeat_pulse", 32'(io.btn_pulse[1]), 0);
`endif
    io.btn_raw = '0;
    step(8);
    chk("final_level", 32'(io.btn_level), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
